// File: rtl/gun_cursor_ctrl.sv
// Joystick-to-light-gun cursor: per-axis hold/accelerate FSMs with saturating positions.
// Optional analog absolute mode is compiled in with `define GUN_ANALOG_EN.
module gun_cursor_ctrl #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned POS_W       = 6,
    parameter int unsigned DIV_MAX     = 3,
    parameter int unsigned ACCEL_STEPS = 8,
    parameter int unsigned MAX_STEP    = 4
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic                         tick,
    input  logic [4*NUM_PLAYERS-1:0]     joy_dir,
    input  logic [NUM_PLAYERS-1:0]       recenter,
    input  logic [NUM_PLAYERS-1:0]       ana_en,
    input  logic [8*NUM_PLAYERS-1:0]     ana_x,
    input  logic [8*NUM_PLAYERS-1:0]     ana_y,
    output logic [POS_W*NUM_PLAYERS-1:0] gun_h,
    output logic [POS_W*NUM_PLAYERS-1:0] gun_v,
    output logic [NUM_PLAYERS-1:0]       moving
);

    localparam int unsigned DIV_W = $clog2(DIV_MAX + 1);
    localparam int unsigned RUN_W = $clog2(ACCEL_STEPS + 1);

    localparam logic [POS_W-1:0] CENTRE    = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic [POS_W-1:0] STEP_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0] STEP_MAX  = POS_W'(MAX_STEP);
    localparam logic [POS_W-1:0] STEP_HALF = POS_W'(MAX_STEP / 2);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV_MAX - 1);
    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(ACCEL_STEPS - 1);

    typedef enum logic [0:0] {StIdle, StHold} axis_st_e;

    logic [NUM_PLAYERS-1:0] hold_h;
    logic [NUM_PLAYERS-1:0] hold_v;

`ifndef GUN_ANALOG_EN
    logic unused_ana;
    assign unused_ana = ^{ana_en, ana_x, ana_y};
`endif

    // Axis a belongs to player a/2; even axes are horizontal, odd are vertical.
    for (genvar a = 0; a < 2 * NUM_PLAYERS; a++) begin : g_axis
        localparam int unsigned P    = a / 2;
        localparam bit          IS_V = (a % 2) == 1;

        logic             neg;
        logic             pos;
        logic             active;
        axis_st_e         st_q;
        logic             dir_q;
        logic [DIV_W-1:0] div_q;
        logic [RUN_W-1:0] run_q;
        logic [POS_W-1:0] step_q;
        logic [POS_W-1:0] pos_q;
        logic [POS_W-1:0] pos_mv;
        logic [POS_W:0]   sum;
        logic [POS_W:0]   diff;

        assign neg    = IS_V ? joy_dir[4*P+3] : joy_dir[4*P+1];
        assign pos    = IS_V ? joy_dir[4*P+2] : joy_dir[4*P];
        assign active = pos ^ neg;

        // One extra bit catches overflow past the top and borrow below zero.
        assign sum    = {1'b0, pos_q} + {1'b0, step_q};
        assign diff   = {1'b0, pos_q} - {1'b0, step_q};
        assign pos_mv = pos ? (sum[POS_W]  ? '1 : sum[POS_W-1:0])
                            : (diff[POS_W] ? '0 : diff[POS_W-1:0]);

`ifdef GUN_ANALOG_EN
        logic [7:0] ana_raw;
        logic [7:0] ana_off;
        assign ana_raw = IS_V ? ana_y[8*P +: 8] : ana_x[8*P +: 8];
        assign ana_off = ana_raw ^ 8'h80;
`endif

        always_ff @(posedge clk_sys) begin
            if (reset || recenter[P]) begin
                st_q   <= StIdle;
                dir_q  <= 1'b0;
                div_q  <= '0;
                run_q  <= '0;
                step_q <= STEP_ONE;
                pos_q  <= CENTRE;
`ifdef GUN_ANALOG_EN
            end else if (tick && ana_en[P]) begin
                st_q   <= StIdle;
                div_q  <= '0;
                run_q  <= '0;
                step_q <= STEP_ONE;
                pos_q  <= ana_off[7 -: POS_W];
`endif
            end else if (tick) begin
                case (st_q)
                    StIdle: begin
                        // step_q is always 1 here, so pos_mv is a unit move.
                        if (active) begin
                            pos_q  <= pos_mv;
                            dir_q  <= pos;
                            div_q  <= '0;
                            run_q  <= '0;
                            step_q <= STEP_ONE;
                            st_q   <= StHold;
                        end
                    end
                    StHold: begin
                        if (!active || (pos != dir_q)) begin
                            st_q   <= StIdle;
                            div_q  <= '0;
                            run_q  <= '0;
                            step_q <= STEP_ONE;
                        end else if (div_q == DIV_LAST) begin
                            pos_q <= pos_mv;
                            div_q <= '0;
                            if (run_q == RUN_LAST) begin
                                step_q <= (step_q >= STEP_HALF) ? STEP_MAX : (step_q << 1);
                                run_q  <= '0;
                            end else begin
                                run_q <= run_q + 1'b1;
                            end
                        end else begin
                            div_q <= div_q + 1'b1;
                        end
                    end
                    default: st_q <= StIdle;
                endcase
            end
        end

        if (IS_V) begin : g_v
            assign gun_v[POS_W*P +: POS_W] = pos_q;
            assign hold_v[P]               = (st_q == StHold);
        end else begin : g_h
            assign gun_h[POS_W*P +: POS_W] = pos_q;
            assign hold_h[P]               = (st_q == StHold);
        end
    end

    assign moving = hold_h | hold_v;

endmodule

// File: tb/tb_gun_cursor_ctrl.sv
// Directed bench for gun_cursor_ctrl (default parameters, analog mode off).
// Stimulus queues expected outputs; a negedge monitor pops and compares them.
module tb_gun_cursor_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic [7:0]  joy_dir = '0;
    logic [1:0]  recenter = '0;
    logic [1:0]  ana_en = '0;
    logic [15:0] ana_x = '0;
    logic [15:0] ana_y = '0;
    logic [11:0] gun_h;
    logic [11:0] gun_v;
    logic [1:0]  moving;

    gun_cursor_ctrl dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .tick     (tick),
        .joy_dir  (joy_dir),
        .recenter (recenter),
        .ana_en   (ana_en),
        .ana_x    (ana_x),
        .ana_y    (ana_y),
        .gun_h    (gun_h),
        .gun_v    (gun_v),
        .moving   (moving)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int          cyc;
        logic [11:0] h;
        logic [11:0] v;
        logic [1:0]  mv;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk_sys) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk_sys) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            cur = sb.pop_front();
            checks++;
            if (cur.cyc != cyc_cnt || gun_h !== cur.h || gun_v !== cur.v || moving !== cur.mv) begin
                errors++;
                $display("FAIL %s: cyc %0d got h=%h v=%h mv=%b, want h=%h v=%h mv=%b (due cyc %0d)",
                         cur.name, cyc_cnt, gun_h, gun_v, moving, cur.h, cur.v, cur.mv, cur.cyc);
            end
        end
    end

    // Expected outputs after the next clock edge; order is P0 h, P1 h, P0 v, P1 v.
    task automatic expect_out(input string name, input int h0, input int h1, input int v0,
                              input int v1, input logic [1:0] mv);
        exp_t e;
        e.cyc  = cyc_cnt + 1;
        e.h    = {6'(h1), 6'(h0)};
        e.v    = {6'(v1), 6'(v0)};
        e.mv   = mv;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic cycle(input logic tk, input logic [7:0] joy, input logic [1:0] rec);
        tick     = tk;
        joy_dir  = joy;
        recenter = rec;
        @(posedge clk_sys);
        #1;
    endtask

    // Hand-computed positions while holding one direction from 32 with a fresh ramp.
    function automatic int up_tab(input int t);
        case (t)
            1:  return 33;
            3:  return 33;
            4:  return 34;
            25: return 41;
            26: return 41;
            28: return 43;
            49: return 57;
            52: return 61;
            55: return 63;
            58: return 63;
            default: return -1;
        endcase
    endfunction

    // Reversal from 63 (step 4) to left: idle tick, then a fresh ramp down to 0.
    function automatic int left_tab(input int t);
        case (t)
            1:  return 63;
            2:  return 62;
            5:  return 61;
            26: return 54;
            29: return 52;
            50: return 38;
            53: return 34;
            77: return 2;
            80: return 0;
            86: return 0;
            default: return -1;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int e;

        expect_out("reset", 32, 32, 32, 32, 2'b00);
        cycle(1'b1, 8'h01, 2'b00);
        reset = 1'b0;

        for (int i = 0; i < 100; i++) begin
            if (i == 0 || i == 99) expect_out("idle", 32, 32, 32, 32, 2'b00);
            cycle(1'b1, 8'h00, 2'b00);
        end

        for (int t = 1; t <= 58; t++) begin
            e = up_tab(t);
            if (e >= 0) expect_out("ramp_right", e, 32, 32, 32, 2'b01);
            cycle(1'b1, 8'h01, 2'b00);
            if (t == 1 || t == 4) begin
                expect_out("no_tick_hold", e, 32, 32, 32, 2'b01);
                cycle(1'b0, 8'h01, 2'b00);
            end
        end

        for (int t = 1; t <= 86; t++) begin
            e = left_tab(t);
            if (e >= 0) expect_out("ramp_left", e, 32, 32, 32, (t == 1) ? 2'b00 : 2'b01);
            cycle(1'b1, 8'h02, 2'b00);
        end

        for (int t = 1; t <= 58; t++) begin
            e = up_tab(t);
            if (e >= 0) expect_out("ramp_down", 0, 32, e, 32, 2'b01);
            cycle(1'b1, 8'h04, 2'b00);
        end

        for (int t = 1; t <= 3; t++) begin
            if (t != 2) expect_out("both_pressed", 0, 32, 63, 32, 2'b00);
            cycle(1'b1, 8'h30, 2'b00);
        end

        for (int t = 1; t <= 4; t++) begin
            if (t == 1) expect_out("p1_right_p0_up", 0, 33, 62, 32, 2'b11);
            if (t == 4) expect_out("p1_right_p0_up", 0, 34, 61, 32, 2'b11);
            cycle(1'b1, 8'h18, 2'b00);
        end
        expect_out("recenter_no_tick", 0, 32, 61, 32, 2'b01);
        cycle(1'b0, 8'h18, 2'b10);
        expect_out("recenter_held", 0, 32, 61, 32, 2'b01);
        cycle(1'b1, 8'h18, 2'b10);
        expect_out("recenter_release", 0, 33, 61, 32, 2'b11);
        cycle(1'b1, 8'h18, 2'b00);
        expect_out("after_release", 0, 33, 60, 32, 2'b11);
        cycle(1'b1, 8'h18, 2'b00);

        reset = 1'b1;
        expect_out("reset_mid_motion", 32, 32, 32, 32, 2'b00);
        cycle(1'b1, 8'h18, 2'b00);
        reset = 1'b0;

        cycle(1'b0, 8'h00, 2'b00);
        cycle(1'b0, 8'h00, 2'b00);
        if (sb.size() != 0) begin
            $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
            checks += sb.size();
            errors += sb.size();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
